// File: rtl/lfsr_sample_buffer.sv
// Steps an external LFSR only when FIFO space is reserved and buffers the words on a valid/ready stream.
// Optional LFSR period monitor: define LFSR_SAMPLE_BUF_PERIOD_EN.
module lfsr_sample_buffer #(
  parameter int NUM_BITS = 16,
  parameter int DEPTH    = 8,
  parameter int CNT_BITS = 16
) (
  input  logic                     i_Clk,
  input  logic                     i_Rst,
  input  logic                     i_Start,
  input  logic [CNT_BITS-1:0]      i_Num_Samples,
  input  logic [NUM_BITS-1:0]      i_LFSR_Data,
  input  logic                     i_LFSR_Done,
  output logic                     o_LFSR_Enable,
  output logic [NUM_BITS-1:0]      o_Data,
  output logic                     o_Valid,
  input  logic                     i_Ready,
  output logic [$clog2(DEPTH):0]   o_Level,
  output logic                     o_Busy,
  output logic                     o_Done,
  output logic [NUM_BITS-1:0]      o_Period,
  output logic                     o_Period_Valid
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t              state_reg, state_next;
  logic [CNT_BITS-1:0] remaining_reg;
  logic                pend_reg;
  logic                done_reg;
  logic [PTR_W-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [LVL_W-1:0]    level_reg;
  logic [NUM_BITS-1:0] mem [DEPTH];

  logic                start_acc;
  logic                lfsr_step;
  logic                push;
  logic                pop;
  logic [LVL_W:0]      reserved;

  assign start_acc = (state_reg == S_IDLE) && i_Start;
  // A step in flight (pend) already owns a slot, so count it against free space.
  assign reserved  = {1'b0, level_reg} + {{LVL_W{1'b0}}, pend_reg};
  assign lfsr_step = (state_reg == S_RUN) && (remaining_reg != '0)
                     && (reserved < (LVL_W+1)'(DEPTH));
  assign push      = pend_reg;
  assign pop       = (level_reg != '0) && i_Ready;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (i_Start && (i_Num_Samples != '0)) state_next = S_RUN;
      S_RUN:   if ((remaining_reg == '0) && !pend_reg) state_next = S_DRAIN;
      S_DRAIN: if (level_reg == '0) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_Busy        = (state_reg != S_IDLE);
    o_LFSR_Enable = lfsr_step;
    o_Valid       = (level_reg != '0);
    o_Level       = level_reg;
    o_Done        = done_reg;
    o_Data        = o_Valid ? mem[rd_ptr_reg] : '0;
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      remaining_reg <= '0;
      pend_reg      <= 1'b0;
      done_reg      <= 1'b0;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      level_reg     <= '0;
    end else begin
      pend_reg <= lfsr_step;
      done_reg <= (start_acc && (i_Num_Samples == '0))
                  || ((state_reg == S_DRAIN) && (level_reg == '0));
      if (start_acc)      remaining_reg <= i_Num_Samples;
      else if (lfsr_step) remaining_reg <= remaining_reg - 1'b1;
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
    end
  end

  always_ff @(posedge i_Clk) begin
    if (push) mem[wr_ptr_reg] <= i_LFSR_Data;
  end

`ifdef LFSR_SAMPLE_BUF_PERIOD_EN
  logic [NUM_BITS-1:0] step_cnt_reg;
  logic [NUM_BITS-1:0] period_reg;
  logic                period_valid_reg;
  logic                seen_done_reg;

  // The first done after a start only aligns the counter; later dones report a period.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      step_cnt_reg     <= '0;
      period_reg       <= '0;
      period_valid_reg <= 1'b0;
      seen_done_reg    <= 1'b0;
    end else if (start_acc) begin
      step_cnt_reg     <= '0;
      period_reg       <= '0;
      period_valid_reg <= 1'b0;
      seen_done_reg    <= 1'b0;
    end else if (pend_reg) begin
      if (i_LFSR_Done) begin
        step_cnt_reg  <= '0;
        seen_done_reg <= 1'b1;
        if (seen_done_reg) begin
          period_reg       <= step_cnt_reg + 1'b1;
          period_valid_reg <= 1'b1;
        end
      end else if (step_cnt_reg != '1) begin
        step_cnt_reg <= step_cnt_reg + 1'b1;
      end
    end
  end

  assign o_Period       = period_reg;
  assign o_Period_Valid = period_valid_reg;
`else
  logic unused_done;
  assign unused_done    = i_LFSR_Done;
  assign o_Period       = '0;
  assign o_Period_Valid = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_sample_buffer.sv
// Directed bench for lfsr_sample_buffer: behavioural LFSR attached, scoreboard of expected words.
// Covers latency, backpressure, zero-count start, async reset, period monitor and ignored restarts.
module tb_lfsr_sample_buffer;
  localparam int NB    = 16;
  localparam int DEPTH = 8;
  localparam int CB    = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_Start;
  logic [CB-1:0] i_Num_Samples;
  logic [NB-1:0] i_LFSR_Data;
  logic          i_LFSR_Done;
  logic          o_LFSR_Enable;
  logic [NB-1:0] o_Data;
  logic          o_Valid;
  logic          i_Ready;
  logic [$clog2(DEPTH):0] o_Level;
  logic          o_Busy;
  logic          o_Done;
  logic [NB-1:0] o_Period;
  logic          o_Period_Valid;

  always #5 clk = ~clk;

  lfsr_sample_buffer #(.NUM_BITS(NB), .DEPTH(DEPTH), .CNT_BITS(CB)) dut (
    .i_Clk(clk), .i_Rst(rst), .i_Start(i_Start), .i_Num_Samples(i_Num_Samples),
    .i_LFSR_Data(i_LFSR_Data), .i_LFSR_Done(i_LFSR_Done), .o_LFSR_Enable(o_LFSR_Enable),
    .o_Data(o_Data), .o_Valid(o_Valid), .i_Ready(i_Ready), .o_Level(o_Level),
    .o_Busy(o_Busy), .o_Done(o_Done), .o_Period(o_Period), .o_Period_Valid(o_Period_Valid)
  );

  // Reference LFSR: 16-bit taps 16,15,13,4 or 4-bit taps 4,3 (zero-extended), both maximal.
  function automatic logic [15:0] lfsr_next(input logic [15:0] r, input bit use4);
    if (use4) return {12'h000, r[2:0], r[3] ^ r[2]};
    return {r[14:0], r[15] ^ r[14] ^ r[12] ^ r[3]};
  endfunction

  localparam logic [15:0] SEED = 16'h0001;
  logic [15:0] lfsr_q = SEED;
  bit          w4 = 1'b0;
  logic        lfsr_load;

  always @(posedge clk) begin
    if (lfsr_load)          lfsr_q <= SEED;
    else if (o_LFSR_Enable) lfsr_q <= lfsr_next(lfsr_q, w4);
  end
  assign i_LFSR_Data = lfsr_q;
  assign i_LFSR_Done = (lfsr_q == SEED);

  logic [15:0] sb[$];
  logic [15:0] ref_q;
  int total = 0, bad = 0;
  int cyc, en_cnt, first_en, done_cnt, done_cyc, delivered, first_valid, last_pop;
  bit busy_seen;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic reseed(input bit use4);
    w4 = use4;
    ref_q = SEED;
    @(negedge clk); lfsr_load = 1'b1;
    @(negedge clk); lfsr_load = 1'b0;
  endtask

  task automatic start(input int n);
    @(negedge clk);
    i_Start = 1'b1;
    i_Num_Samples = CB'(n);
    cyc = 0; en_cnt = 0; first_en = -1; done_cnt = 0; done_cyc = -1;
    delivered = 0; first_valid = -1; last_pop = -1; busy_seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      ref_q = lfsr_next(ref_q, w4);
      sb.push_back(ref_q);
    end
  endtask

  task automatic step(input bit rdy, input bit st);
    logic [15:0] exp;
    @(negedge clk);
    i_Start = st;
    if (st) i_Num_Samples = CB'(3);
    i_Ready = rdy;
    #1;
    cyc++;
    if (o_LFSR_Enable) begin
      en_cnt++;
      if (first_en < 0) first_en = cyc;
    end
    if (o_Done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (o_Busy) busy_seen = 1'b1;
    if (o_Valid && first_valid < 0) first_valid = cyc;
    chk("level_le_depth", 32'(o_Level <= DEPTH), 32'd1);
    if (o_Valid && i_Ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_word", 32'(o_Data), 32'hFFFF_FFFF);
      end else begin
        exp = sb.pop_front();
        chk("word", 32'(o_Data), 32'(exp));
      end
      delivered++;
      last_pop = cyc;
    end
  endtask

  task automatic run_until_done(input bit rand_rdy, input int budget);
    int k = 0;
    while (done_cnt == 0 && k < budget) begin
      step(rand_rdy ? bit'($urandom_range(0, 1)) : 1'b1, 1'b0);
      k++;
    end
    chk("done_timeout", 32'(done_cnt != 0), 32'd1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
  endtask

  initial begin
    int k;
    rst = 1'b1; i_Start = 1'b0; i_Num_Samples = '0; i_Ready = 1'b0; lfsr_load = 1'b1;
    repeat (3) @(negedge clk);
    lfsr_load = 1'b0;
    chk("rst_valid", 32'(o_Valid), 0);
    chk("rst_level", 32'(o_Level), 0);
    chk("rst_busy", 32'(o_Busy), 0);
    chk("rst_enable", 32'(o_LFSR_Enable), 0);
    chk("rst_done", 32'(o_Done), 0);
    chk("rst_data", 32'(o_Data), 0);
    chk("rst_period_valid", 32'(o_Period_Valid), 0);
    @(negedge clk); rst = 1'b0;

    // 1: N=5, always ready
    reseed(1'b0);
    start(5);
    run_until_done(1'b0, 50);
    chk("t1_first_valid", 32'(first_valid), 32'd3);
    chk("t1_first_en", 32'(first_en), 32'd1);
    chk("t1_en_cnt", 32'(en_cnt), 32'd5);
    chk("t1_delivered", 32'(delivered), 32'd5);
    chk("t1_done_cnt", 32'(done_cnt), 32'd1);
    chk("t1_done_after_pop", 32'(done_cyc > last_pop), 32'd1);
    chk("t1_sb_empty", 32'(sb.size()), 0);

    // 2: backpressure, N=20 into DEPTH=8
    reseed(1'b0);
    start(20);
    for (int i = 0; i < 15; i++) step(1'b0, 1'b0);
    chk("t2_level_full", 32'(o_Level), 32'(DEPTH));
    chk("t2_enable_low", 32'(o_LFSR_Enable), 0);
    chk("t2_en_cnt_hold", 32'(en_cnt), 32'(DEPTH));
    run_until_done(1'b0, 100);
    chk("t2_delivered", 32'(delivered), 32'd20);
    chk("t2_en_cnt", 32'(en_cnt), 32'd20);
    chk("t2_done_cnt", 32'(done_cnt), 32'd1);
    chk("t2_done_after_pop", 32'(done_cyc > last_pop), 32'd1);

    // 3: N=0
    start(0);
    run_until_done(1'b0, 10);
    chk("t3_done_cnt", 32'(done_cnt), 32'd1);
    chk("t3_done_cyc", 32'(done_cyc), 32'd1);
    chk("t3_en_cnt", 32'(en_cnt), 0);
    chk("t3_busy", 32'(busy_seen), 0);

    // 4: asynchronous reset mid-run
    reseed(1'b0);
    start(10);
    k = 0;
    while (delivered < 3 && k < 50) begin
      step(1'b1, 1'b0);
      k++;
    end
    chk("t4_reach3", 32'(delivered), 32'd3);
    #1 rst = 1'b1;
    #1;
    chk("t4_async_valid", 32'(o_Valid), 0);
    chk("t4_async_enable", 32'(o_LFSR_Enable), 0);
    chk("t4_async_busy", 32'(o_Busy), 0);
    chk("t4_async_level", 32'(o_Level), 0);
    @(negedge clk); rst = 1'b0;
    sb.delete();
    reseed(1'b0);
    start(2);
    run_until_done(1'b0, 30);
    chk("t4_delivered", 32'(delivered), 32'd2);
    chk("t4_sb_empty", 32'(sb.size()), 0);

    // 5: period monitor with a 4-bit LFSR
    reseed(1'b1);
    start(40);
    run_until_done(1'b0, 200);
    chk("t5_delivered", 32'(delivered), 32'd40);
`ifdef LFSR_SAMPLE_BUF_PERIOD_EN
    chk("t5_period", 32'(o_Period), 32'd15);
    chk("t5_period_valid", 32'(o_Period_Valid), 32'd1);
`else
    chk("t5_period", 32'(o_Period), 0);
    chk("t5_period_valid", 32'(o_Period_Valid), 0);
`endif

    // 6: random ready, extra start while busy
    reseed(1'b0);
    start(16);
    for (int i = 0; i < 6; i++) step(bit'($urandom_range(0, 1)), i == 4);
    chk("t6_busy_at_restart", 32'(busy_seen), 32'd1);
    run_until_done(1'b1, 400);
    chk("t6_delivered", 32'(delivered), 32'd16);
    chk("t6_en_cnt", 32'(en_cnt), 32'd16);
    chk("t6_done_cnt", 32'(done_cnt), 32'd1);
    chk("t6_sb_empty", 32'(sb.size()), 0);
    chk("t6_period_valid_cleared", 32'(o_Period_Valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
